// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the mips system-bus bridge
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] RDATA_ERR = 32'h0;
  localparam int          HW_INT_W  = 6;

endpackage

// File: rtl/mips_irq_sync.sv
// rtl/mips_irq_sync.sv - two-flop synchroniser for asynchronous level interrupts
module mips_irq_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mips_bus_bridge.sv
// rtl/mips_bus_bridge.sv - CPU data port to N_DEV peripheral windows, one transfer in flight
module mips_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int          N_DEV     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          WIN_SIZE  = 16,
  parameter int          TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [N_DEV-1:0]      dev_req,
  output logic                  dev_we,
  output logic [$clog2(WIN_SIZE)-1:0] dev_addr,
  output logic [31:0]           dev_wdata,
  output logic [3:0]            dev_be,
  input  logic [32*N_DEV-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]      dev_ack,
  input  logic [N_DEV-1:0]      dev_irq,
  output logic [HW_INT_W-1:0]   hw_int
);

  localparam int OFF_W = $clog2(WIN_SIZE);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(N_DEV * WIN_SIZE);

  if (N_DEV < 1 || N_DEV > HW_INT_W) begin : g_bad_ndev
    $error("mips_bus_bridge: N_DEV must be 1..6");
  end
  if (WIN_SIZE < 4 || (WIN_SIZE & (WIN_SIZE - 1)) != 0) begin : g_bad_win
    $error("mips_bus_bridge: WIN_SIZE must be a power of two >= 4");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mips_bus_bridge: TIMEOUT must be >= 1");
  end
  if (END_ADDR > 33'h1_0000_0000) begin : g_bad_range
    $error("mips_bus_bridge: device windows run past the top of the address space");
  end

  state_t             state, state_d;
  logic [N_DEV-1:0]   hit_vec;
  logic [N_DEV-1:0]   dev_req_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               latch_req;
  logic               ack_hit;
  logic [31:0]        sel_rdata;
  logic [N_DEV-1:0]   irq_s;

  // Full 33-bit compare so a window ending exactly at 2^32 never wraps.
  for (genvar g = 0; g < N_DEV; g++) begin : g_dec
    localparam logic [32:0] LO = {1'b0, BASE_ADDR} + 33'(g * WIN_SIZE);
    localparam logic [32:0] HI = LO + 33'(WIN_SIZE);
    assign hit_vec[g] = ({1'b0, cpu_addr} >= LO) && ({1'b0, cpu_addr} < HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    dev_req_d = dev_req;
    cnt_d     = cnt;
    rdata_d   = rdata_q;
    err_d     = err_q;
    latch_req = 1'b0;
    ack_hit   = |(dev_ack & dev_req);
    sel_rdata = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_req[i]) sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
    end
    case (state)
      IDLE: begin
        if (cpu_req) begin
          latch_req = 1'b1;
          if (|hit_vec && cpu_addr[1:0] == 2'b00) begin
            dev_req_d = hit_vec;
            cnt_d     = '0;
            state_d   = ACCESS;
          end else begin
            rdata_d = RDATA_ERR;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          rdata_d   = dev_we ? 32'h0 : sel_rdata;
          err_d     = 1'b0;
          dev_req_d = '0;
          state_d   = RESP;
        end else if (cnt == CNT_LAST) begin
          rdata_d   = RDATA_ERR;
          err_d     = 1'b1;
          dev_req_d = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        // Response registers are cleared on the way out so they read 0 while idle.
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cpu_ready = (state == RESP);
    cpu_rdata = rdata_q;
    cpu_err   = err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dev_req   <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
    end else begin
      dev_req <= dev_req_d;
      cnt     <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch_req) begin
        dev_we    <= cpu_we;
        dev_addr  <= cpu_addr[OFF_W-1:0];
        dev_wdata <= cpu_wdata;
        dev_be    <= cpu_be;
      end
    end
  end

  mips_irq_sync #(
    .WIDTH(N_DEV)
  ) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (dev_irq),
    .q     (irq_s)
  );

  always_comb begin
    hw_int = '0;
    hw_int[N_DEV-1:0] = irq_s;
  end

endmodule

// File: tb/tb_mips_bus_bridge.sv
// tb/tb_mips_bus_bridge.sv - table-driven scoreboard bench for mips_bus_bridge
module tb_mips_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [1:0]  dev_req;
  logic        dev_we;
  logic [3:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_be;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_ack, dev_irq;
  logic [5:0]  hw_int;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mips_bus_bridge #(
    .N_DEV(2), .BASE_ADDR(32'h0000_7F00), .WIN_SIZE(16), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_be(dev_be), .dev_rdata(dev_rdata), .dev_ack(dev_ack), .dev_irq(dev_irq),
    .hw_int(hw_int)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;     // ack on ACCESS cycle waits+1; <0 drives ack_mask every cycle
    logic [1:0]  ack_mask;
    logic [31:0] devdata;
    logic [1:0]  exp_req;
    logic [3:0]  exp_off;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cyc, acc;
    bit   done;
    @(negedge clk);
    cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_be = v.be; cpu_req = 1'b1;
    dev_ack = 2'b00;
    dev_rdata = (v.exp_req == 2'b10) ? {v.devdata, ~v.devdata} : {~v.devdata, v.devdata};
    sbq.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat,
                    acc: (v.exp_req != 2'b00) ? v.exp_lat - 1 : 0});
    @(posedge clk);
    cyc = 0; acc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin
        done = 1;
        if (sbq.size() == 0) begin
          check("sb_empty_on_ready", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
          check("cpu_err", 64'(cpu_err), 64'(e.err));
          check("latency", 64'(cyc), 64'(e.lat));
          check("access_cycles", 64'(acc), 64'(e.acc));
        end
        check("dev_req_in_resp", 64'(dev_req), 64'd0);
      end else if (cyc > 40) begin
        check("ready_never_came", 64'd0, 64'd1);
        done = 1;
      end else begin
        acc++;
        check("dev_req", 64'(dev_req), 64'(v.exp_req));
        check("dev_fields", 64'({dev_we, dev_addr, dev_be, dev_wdata}),
              64'({v.we, v.exp_off, v.be, v.wdata}));
        if (v.waits < 0) dev_ack = v.ack_mask;
        else             dev_ack = (acc == v.waits + 1) ? v.ack_mask : 2'b00;
      end
    end
    cpu_req = 1'b0;
    dev_ack = 2'b00;
    @(negedge clk);
    check("idle_after_resp", 64'({cpu_ready, cpu_err, cpu_rdata}), 64'd0);
  endtask

  task automatic irq_seq();
    repeat (3) @(negedge clk);
    dev_irq = 2'b10;
    @(negedge clk);
    check("hw_int_1edge", 64'(hw_int), 64'd0);
    @(negedge clk);
    check("hw_int_2edge", 64'(hw_int), 64'b000010);
    dev_irq = 2'b00;
    repeat (2) @(negedge clk);
    check("hw_int_clear", 64'(hw_int), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt;
    //           we    addr          wdata          be     wt  ackm   devdata        req    off    rdata          err  lat
    vecs.push_back('{1'b0, 32'h0000_7F14, 32'h0,         4'hF,  0, 2'b10, 32'h1234_5678, 2'b10, 4'h4, 32'h1234_5678, 1'b0,  2});
    vecs.push_back('{1'b1, 32'h0000_7F08, 32'hCAFE_F00D, 4'h3,  3, 2'b01, 32'h5555_AAAA, 2'b01, 4'h8, 32'h0,         1'b0,  5});
    vecs.push_back('{1'b0, 32'h0000_7F20, 32'h0,         4'hF,  0, 2'b00, 32'h0,         2'b00, 4'h0, 32'h0,         1'b1,  1});
    vecs.push_back('{1'b0, 32'h0000_7F02, 32'h0,         4'hF,  0, 2'b00, 32'h0,         2'b00, 4'h0, 32'h0,         1'b1,  1});
    vecs.push_back('{1'b0, 32'h0000_7EFC, 32'h0,         4'hF,  0, 2'b00, 32'h0,         2'b00, 4'h0, 32'h0,         1'b1,  1});
    vecs.push_back('{1'b0, 32'h0000_7F1C, 32'h0,         4'h0,  1, 2'b10, 32'hA5A5_0001, 2'b10, 4'hC, 32'hA5A5_0001, 1'b0,  3});
    vecs.push_back('{1'b0, 32'h0000_7F04, 32'h0,         4'hF, 14, 2'b01, 32'h0BAD_CAFE, 2'b01, 4'h4, 32'h0BAD_CAFE, 1'b0, 16});
    vecs.push_back('{1'b1, 32'h0000_7F10, 32'h0000_0077, 4'h0,  0, 2'b10, 32'hFFFF_0000, 2'b10, 4'h0, 32'h0,         1'b0,  2});
    vecs.push_back('{1'b1, 32'h0000_8000, 32'h1111_2222, 4'hF,  0, 2'b00, 32'h0,         2'b00, 4'h0, 32'h0,         1'b1,  1});
    vecs.push_back('{1'b0, 32'h0000_7F0E, 32'h0,         4'hF,  0, 2'b00, 32'h0,         2'b00, 4'h0, 32'h0,         1'b1,  1});

    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    dev_rdata = '0; dev_ack = '0; dev_irq = '0;
    repeat (3) @(negedge clk);
    check("reset_cpu", 64'({cpu_ready, cpu_err, cpu_rdata}), 64'd0);
    check("reset_dev", 64'({dev_req, dev_we, dev_addr, dev_be, dev_wdata}), 64'd0);
    check("reset_hw_int", 64'(hw_int), 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout with a stray ack from the unselected device, interrupts arriving meanwhile.
    vt = '{1'b0, 32'h0000_7F00, 32'h0, 4'hF, -1, 2'b10, 32'h7777_8888, 2'b01, 4'h0, 32'h0, 1'b1, 16};
    fork
      run_vec(vt);
      irq_seq();
    join

    // Reset asserted mid-ACCESS drops dev_req with no clock edge and yields no response.
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h0000_7F00; cpu_be = 4'hF; cpu_req = 1'b1; dev_ack = 2'b00;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("pre_reset_dev_req", 64'(dev_req), 64'b01);
    #2 reset = 1'b0;
    #1;
    check("async_reset_dev_req", 64'(dev_req), 64'd0);
    check("async_reset_ready", 64'({cpu_ready, cpu_err}), 64'd0);
    cpu_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("no_ready_in_reset", 64'(cpu_ready), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("no_ready_after_reset", 64'(cpu_ready), 64'd0);
    run_vec(vecs[0]);

    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
